if_program_loader: RTL and testbench

IF_PROGRAM_LOADER -- requirements
Module: if_program_loader

---
 rtl/if_program_loader.sv | 132 +++++++++++++
 tb/tb_if_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_program_loader.sv
// Serial program loader for the fetch stage. It assembles received bytes into
// big-endian words, writes each byte to instruction memory and releases the PC on HALT.
module if_program_loader #(
    parameter int                        NB_MEM_WIDTH   = 8,
    parameter int                        NB_INSTRUCTION = 32,
    parameter int                        N_INSN_MAX     = 64,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = 32'hFFFFFFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_load_request,
    input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_IF_write_enable,
    output logic [NB_MEM_WIDTH-1:0] o_IF_write_data,
    output logic                    o_IF_pc_reset,
    output logic                    o_IF_pc_enable,
    output logic [6:0]              o_insn_count,
    output logic                    o_loading,
    output logic                    o_done,
    output logic                    o_error
);

    localparam int         NB_PARTIAL  = NB_INSTRUCTION - NB_MEM_WIDTH;
    localparam logic [6:0] LP_INSN_MAX = 7'(N_INSN_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_byte_cnt;
    logic [NB_PARTIAL-1:0]   r_partial;
    logic [6:0]              r_insn_count;
    logic                    r_write_enable;
    logic [NB_MEM_WIDTH-1:0] r_write_data;
    logic                    r_pc_reset;
    logic                    r_pc_enable;
    logic                    r_loading;
    logic                    r_done;
    logic                    r_error;

    logic                      w_accept;
    logic                      w_word_done;
    logic [NB_INSTRUCTION-1:0] w_word;
    logic [6:0]                w_count_inc;

    // A load request wins over a coincident byte strobe, so that byte is never accepted.
    always_comb begin
        w_accept    = (r_state == ST_LOAD) && i_rx_valid && !i_load_request;
        w_word      = {r_partial, i_rx_data};
        w_word_done = w_accept && (r_byte_cnt == 2'd3);
        w_count_inc = r_insn_count + 7'd1;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_byte_cnt     <= 2'd0;
            r_partial      <= '0;
            r_insn_count   <= 7'd0;
            r_write_enable <= 1'b0;
            r_write_data   <= '0;
            r_pc_reset     <= 1'b1;
            r_pc_enable    <= 1'b0;
            r_loading      <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_write_enable <= w_accept;
            if (w_accept) begin
                r_write_data <= i_rx_data;
            end

            if (i_load_request) begin
                r_state      <= ST_LOAD;
                r_byte_cnt   <= 2'd0;
                r_partial    <= '0;
                r_insn_count <= 7'd0;
                r_pc_reset   <= 1'b1;
                r_pc_enable  <= 1'b0;
                r_loading    <= 1'b1;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_partial  <= w_word[NB_PARTIAL-1:0];
                        end
                        if (w_word_done) begin
                            r_insn_count <= w_count_inc;
                            if (w_word == HALT_WORD) begin
                                r_state <= ST_DRAIN;
                            end else if (w_count_inc == LP_INSN_MAX) begin
                                r_state   <= ST_ERROR;
                                r_loading <= 1'b0;
                                r_error   <= 1'b1;
                            end
                        end
                    end
                    // The last byte is being written this cycle; the PC is freed afterwards.
                    ST_DRAIN: begin
                        r_state     <= ST_RUN;
                        r_loading   <= 1'b0;
                        r_done      <= 1'b1;
                        r_pc_reset  <= 1'b0;
                        r_pc_enable <= 1'b1;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign o_IF_write_enable = r_write_enable;
    assign o_IF_write_data   = r_write_data;
    assign o_IF_pc_reset     = r_pc_reset;
    assign o_IF_pc_enable    = r_pc_enable;
    assign o_insn_count      = r_insn_count;
    assign o_loading         = r_loading;
    assign o_done            = r_done;
    assign o_error           = r_error;

endmodule

// File: tb/tb_if_program_loader.sv
// Self-checking bench for if_program_loader: two instances (default limit and a
// limit of four words) share stimulus and are compared to a behavioural model every cycle.
module tb_if_program_loader;

   localparam int PH_IDLE  = 0;
   localparam int PH_LOAD  = 1;
   localparam int PH_DRAIN = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_ERROR = 4;

   logic clock;
   logic resetN;
   logic loadReq;
   logic rxValid;
   logic [7:0] rxData;

   logic [1:0] we;
   logic [1:0][7:0] wd;
   logic [1:0] pcr;
   logic [1:0] pce;
   logic [1:0][6:0] cnt;
   logic [1:0] ld;
   logic [1:0] dn;
   logic [1:0] er;

   int compared;
   int mismatched;

   int mPhase[2];
   int mBytes[2];
   int mCnt[2];
   int mMax[2];
   logic [31:0] mWord[2];
   logic mWe[2];
   logic [7:0] mWd[2];

   if_program_loader #(.N_INSN_MAX(64)) dutDefault (
      .i_clock(clock), .i_reset_n(resetN), .i_load_request(loadReq),
      .i_rx_data(rxData), .i_rx_valid(rxValid),
      .o_IF_write_enable(we[0]), .o_IF_write_data(wd[0]),
      .o_IF_pc_reset(pcr[0]), .o_IF_pc_enable(pce[0]), .o_insn_count(cnt[0]),
      .o_loading(ld[0]), .o_done(dn[0]), .o_error(er[0])
   );

   if_program_loader #(.N_INSN_MAX(4)) dutSmall (
      .i_clock(clock), .i_reset_n(resetN), .i_load_request(loadReq),
      .i_rx_data(rxData), .i_rx_valid(rxValid),
      .o_IF_write_enable(we[1]), .o_IF_write_data(wd[1]),
      .o_IF_pc_reset(pcr[1]), .o_IF_pc_enable(pce[1]), .o_insn_count(cnt[1]),
      .o_loading(ld[1]), .o_done(dn[1]), .o_error(er[1])
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      assert (act === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mPhase[i] = PH_IDLE;
         mBytes[i] = 0;
         mCnt[i]   = 0;
         mWord[i]  = 32'h0;
         mWe[i]    = 1'b0;
         mWd[i]    = 8'h00;
      end
   endtask

   // One rising edge of the reference model, driven by the inputs sampled there.
   task automatic modelEdge(input logic load, input logic valid, input logic [7:0] data);
      for (int i = 0; i < 2; i++) begin
         mWe[i] = 1'b0;
         if (load) begin
            mPhase[i] = PH_LOAD;
            mBytes[i] = 0;
            mCnt[i]   = 0;
            mWord[i]  = 32'h0;
         end else if (mPhase[i] == PH_LOAD) begin
            if (valid) begin
               mWe[i]    = 1'b1;
               mWd[i]    = data;
               mWord[i]  = (mWord[i] << 8) | 32'(data);
               mBytes[i] = mBytes[i] + 1;
               if (mBytes[i] % 4 == 0) begin
                  mCnt[i] = mCnt[i] + 1;
                  if (mWord[i] == 32'hFFFFFFFF) mPhase[i] = PH_DRAIN;
                  else if (mCnt[i] == mMax[i]) mPhase[i] = PH_ERROR;
               end
            end
         end else if (mPhase[i] == PH_DRAIN) begin
            mPhase[i] = PH_RUN;
         end
      end
   endtask

   task automatic checkOutput();
      for (int i = 0; i < 2; i++) begin
         check("write_enable", i, 32'(we[i]), 32'(mWe[i]));
         check("write_data", i, 32'(wd[i]), 32'(mWd[i]));
         check("pc_reset", i, 32'(pcr[i]), 32'(mPhase[i] != PH_RUN));
         check("pc_enable", i, 32'(pce[i]), 32'(mPhase[i] == PH_RUN));
         check("insn_count", i, 32'(cnt[i]), 32'(mCnt[i]));
         check("loading", i, 32'(ld[i]), 32'(mPhase[i] == PH_LOAD || mPhase[i] == PH_DRAIN));
         check("done", i, 32'(dn[i]), 32'(mPhase[i] == PH_RUN));
         check("error", i, 32'(er[i]), 32'(mPhase[i] == PH_ERROR));
      end
   endtask

   // Drive one cycle of inputs on the falling edge, then check just after the rising edge.
   task automatic applyStimulus(input logic load, input logic valid, input logic [7:0] data);
      @(negedge clock);
      loadReq = load;
      rxValid = valid;
      rxData  = data;
      @(posedge clock);
      modelEdge(load, valid, data);
      #1;
      checkOutput();
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b0, 1'b1, b);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00);
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) sendByte(w[k*8 +: 8]);
   endtask

   initial begin
      logic [31:0] randWord;
      int nWords;
      compared   = 0;
      mismatched = 0;
      mMax[0]    = 64;
      mMax[1]    = 4;
      resetN     = 1'b0;
      loadReq    = 1'b0;
      rxValid    = 1'b0;
      rxData     = 8'h00;
      modelReset();

      // Reset state, held across edges.
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput();
      @(negedge clock);
      resetN = 1'b1;

      // Bytes in IDLE are ignored and the loader stays idle.
      sendByte(8'h5A);
      idleCycles(2);
      check("idle_count_const", 0, 32'(cnt[0]), 32'd0);

      // Basic load, back-to-back bytes: 20 01 00 05 FF FF FF FF.
      applyStimulus(1'b1, 1'b0, 8'h00);
      sendWord(32'h20010005);
      sendWord(32'hFFFFFFFF);
      check("drain_loading_const", 0, 32'(ld[0]), 32'd1);
      check("drain_last_write_const", 0, 32'(we[0]), 32'd1);
      idleCycles(1);
      check("run_count_const", 0, 32'(cnt[0]), 32'd2);
      check("run_pc_enable_const", 0, 32'(pce[0]), 32'd1);
      check("run_pc_reset_const", 0, 32'(pcr[0]), 32'd0);

      // Bytes in RUN are ignored.
      sendByte(8'h13);
      sendByte(8'h37);
      idleCycles(1);

      // Reload from RUN, with a byte coincident with the request.
      applyStimulus(1'b1, 1'b1, 8'hAB);
      check("reload_pc_reset_const", 0, 32'(pcr[0]), 32'd1);
      check("reload_done_const", 0, 32'(dn[0]), 32'd0);
      check("reload_count_const", 0, 32'(cnt[0]), 32'd0);
      idleCycles(1);
      sendWord(32'hDEADBEEF);
      sendWord(32'hFFFFFFFF);
      idleCycles(2);

      // Overflow on the four-word instance; the wide instance keeps loading.
      applyStimulus(1'b1, 1'b0, 8'h00);
      sendWord(32'h11223344);
      sendWord(32'h55667788);
      sendWord(32'h99AABBCC);
      sendWord(32'hDDEEF001);
      check("overflow_error_const", 1, 32'(er[1]), 32'd1);
      check("overflow_pc_reset_const", 1, 32'(pcr[1]), 32'd1);
      sendByte(8'h42);
      check("overflow_blocked_const", 1, 32'(we[1]), 32'd0);
      idleCycles(2);

      // Asynchronous reset in the middle of a cycle after six bytes.
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 6; k++) sendByte(8'(8'h30 + k));
      #3;
      resetN = 1'b0;
      #1;
      modelReset();
      checkOutput();
      @(posedge clock);
      #1;
      checkOutput();
      @(negedge clock);
      resetN = 1'b1;
      idleCycles(2);
      applyStimulus(1'b1, 1'b0, 8'h00);
      sendWord(32'h01020304);
      check("after_reset_count_const", 0, 32'(cnt[0]), 32'd1);

      // Partial word discarded on restart.
      sendByte(8'hFF);
      sendByte(8'hFF);
      applyStimulus(1'b1, 1'b0, 8'h00);
      sendWord(32'hFFFFFFFF);
      idleCycles(2);

      // Randomized programs with random gaps, optional HALT and stray strobes.
      for (int p = 0; p < 10; p++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
         nWords = int'($urandom_range(1, 6));
         for (int w = 0; w < nWords; w++) begin
            randWord = $urandom;
            for (int k = 3; k >= 0; k--) begin
               idleCycles(int'($urandom_range(0, 2)));
               sendByte(randWord[k*8 +: 8]);
            end
         end
         if ($urandom_range(0, 3) != 0) begin
            sendWord(32'hFFFFFFFF);
         end else begin
            sendByte(8'($urandom));
         end
         for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
